hqc_encap_ct_streamer: RTL
==========================

// Module: hqc_encap_ct_streamer
// PURPOSE
//  Downstream consumer of hqc_kem_joint_design encap results. After encap done, walks the encap_out read port in order u, v, d, ss.
//  Byte-reverses each 128-bit RAM word into wire order.
//  Emits a 32-bit valid/ready stream with byte-keep, section tag and last flags, replacing the bench-style fixed-delay readout.
// PARAMETERS
//  parameter_set  "hqc256"  selects U_BYTES/V_BYTES defaults ("hqc128"/"hqc192"/"hqc256")
//  RAMWIDTH       128       encap_out word width; must be 128
//  U_BYTES        7205      u length in bytes, N_B/8 (hqc128 2209, hqc192 4482)
//  V_BYTES        7200      v length in bytes, n1*n2/8 (hqc128 2208, hqc192 4480)
//  D_WORDS        16        32-bit words of d
//  SS_WORDS       16        32-bit words of ss
//  ADDR_W         9         encap_out_addr width, CLOG2(ceil(U_BYTES/16))
// PORTS
//  clk              in   1        system clock
//  rst              in   1        asynchronous active-low reset
//  start            in   1        one-cycle pulse; begin readout (tie to encap done)
//  busy             out  1        high from accepted start until final beat handshake
//  encap_out_en     out  1        read enable to encap result RAMs
//  encap_out_type   out  2        0=ss 1=d 2=u 3=v
//  encap_out_addr   out  ADDR_W   word address
//  encap_out        in   128      read data, valid exactly 1 cycle after en/addr/type
//  dout             out  32       stream data; first wire byte in [31:24]
//  dout_keep        out  4        valid bytes, MSB-aligned (4'b1000 = [31:24] only)
//  dout_type        out  2        section tag, same coding as encap_out_type
//  dout_last_sec    out  1        last beat of current section
//  dout_last        out  1        last beat of whole transfer (last ss word)
//  dout_valid       out  1        stream valid
//  dout_ready       in   1        stream ready; beat transfers when valid&ready
// BEHAVIOUR
//  Reset: every output 0; FSM returns to IDLE, counters and buffers clear.
//   Reset mid-transfer abandons it; no further beats are emitted.
//  FSM: IDLE -> SEC_U -> SEC_V -> SEC_D -> SEC_SS -> FLUSH -> IDLE.
//   start is honoured only in IDLE; while busy it is ignored.
//  Byte order: wire byte k of a word = encap_out[127-8k -: 8], k=0..15.
//   The beat sequence for one u/v word is wire bytes 0-3, 4-7, 8-11, 12-15.
//  u/v: ceil(BYTES/16) RAM reads at addr 0.. .
//   Beats stop at byte BYTES-1. The last beat carries keep = top (BYTES%4) bits, or 4'b1111 when the remainder is 0.
//   Unused bytes are driven 0.
//  d/ss: one read per word at addr 0..WORDS-1. Beat = encap_out[127:96], keep 4'b1111.
//  Read pipeline: a 2-entry 128-bit word buffer.
//   A read is issued only when a free entry exists, counting in-flight reads.
//   The buffer never overflows under any dout_ready pattern.
//  Stream rules:
//   - once dout_valid=1, dout/keep/type/last flags hold stable until the handshake;
//   - valid never drops without a handshake;
//   - a section switch needs no bubble.
//  Latency: start sampled at cycle 0 -> en/addr0/type2 at cycle 1 -> data at 2 -> dout_valid at 3.
//  Throughput with dout_ready=1: u/v sustain 1 beat/cycle; d/ss at least 1 beat per 2 cycles.
//  dout_last_sec asserts on the final beat of each section. dout_last asserts together with it on the ss final beat.
//  busy falls the cycle after that handshake, FSM back in IDLE. start is accepted again the cycle after busy falls.
//  encap_out_en=0 whenever no read is issued. Address and type never change while a read for them is in flight.
// TESTING
//  T1 hqc256, dout_ready=1, known u/v/d/ss images -> 1802 u, 1800 v, 16 d, 16 ss beats (3634 total).
//     Byte-exact versus u/v/d/ss_output_256.out. u last keep=4'b1000; v last keep=4'b1111.
//  T2 hqc128 -> u 553 beats, last keep 4'b1000; v 552 beats; dout_last only on beat 1137.
//  T3 random dout_ready (50%) -> same byte stream as T1.
//     No data change while valid&!ready. No read issued with 2 buffered plus in-flight words.
//  T4 timing: start at cycle 0 -> first dout_valid at cycle 3. u/v section at ready=1 has no idle cycle.
//  T5 rst low mid-v section -> all outputs 0 within the same cycle.
//     After release: idle until a new start, then full correct stream from u addr 0.
//  T6 start pulses while busy -> ignored; beat count and data identical to T1.

Source files
------------

// File: rtl/hqc_encap_ct_streamer.sv
// Reads the HQC encapsulation result RAMs (u, v, d, ss) after encap completes and
// emits them as a 32-bit valid/ready byte stream in wire order with keep and tags.
module hqc_encap_ct_streamer #(
    parameter string PARAMETER_SET = "hqc256",
    parameter int    RAMWIDTH      = 128,
    parameter int    U_BYTES       = (PARAMETER_SET == "hqc128") ? 2209 :
                                     (PARAMETER_SET == "hqc192") ? 4482 : 7205,
    parameter int    V_BYTES       = (PARAMETER_SET == "hqc128") ? 2208 :
                                     (PARAMETER_SET == "hqc192") ? 4480 : 7200,
    parameter int    D_WORDS       = 16,
    parameter int    SS_WORDS      = 16,
    parameter int    ADDR_W        = $clog2((U_BYTES + 15) / 16)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    output logic                busy_o,
    output logic                encap_out_en_o,
    output logic [1:0]          encap_out_type_o,
    output logic [ADDR_W-1:0]   encap_out_addr_o,
    input  logic [RAMWIDTH-1:0] encap_out_i,
    output logic [31:0]         dout_o,
    output logic [3:0]          dout_keep_o,
    output logic [1:0]          dout_type_o,
    output logic                dout_last_sec_o,
    output logic                dout_last_o,
    output logic                dout_valid_o,
    input  logic                dout_ready_i
);

    localparam int CNT_W   = 16;
    localparam int U_WORDS = (U_BYTES + 15) / 16;
    localparam int V_WORDS = (V_BYTES + 15) / 16;

    localparam logic [1:0] T_SS = 2'd0;
    localparam logic [1:0] T_D  = 2'd1;
    localparam logic [1:0] T_U  = 2'd2;
    localparam logic [1:0] T_V  = 2'd3;

    localparam logic [ADDR_W-1:0] U_LAST  = ADDR_W'(U_WORDS - 1);
    localparam logic [ADDR_W-1:0] V_LAST  = ADDR_W'(V_WORDS - 1);
    localparam logic [ADDR_W-1:0] D_LAST  = ADDR_W'(D_WORDS - 1);
    localparam logic [ADDR_W-1:0] SS_LAST = ADDR_W'(SS_WORDS - 1);

    localparam logic [CNT_W-1:0] U_LEN  = CNT_W'(U_BYTES);
    localparam logic [CNT_W-1:0] V_LEN  = CNT_W'(V_BYTES);
    localparam logic [CNT_W-1:0] D_LEN  = CNT_W'(D_WORDS);
    localparam logic [CNT_W-1:0] SS_LEN = CNT_W'(SS_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_U,
        S_V,
        S_D,
        S_SS,
        S_FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_active;
    logic [1:0]          rd_type;
    logic [ADDR_W-1:0]   rd_last;
    state_e              rd_next;
    logic                issue;
    logic                infl_q;

    logic [RAMWIDTH-1:0] buf_q [2];
    logic [1:0]          tag_q [2];
    logic                wptr_q, rptr_q;
    logic [1:0]          cnt_q, cnt_d;

    logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
    logic [RAMWIDTH-1:0] head_word;
    logic [1:0]          head_tag;
    logic                head_valid;
    logic [CNT_W-1:0]    sec_len;
    logic [CNT_W-1:0]    remaining;
    logic [1:0]          beat_idx;
    logic [31:0]         slice;
    logic [3:0]          keep;
    logic                last_sec;
    logic                word_done;
    logic [CNT_W-1:0]    step;
    logic                hs;
    logic                pop;
    logic                final_hs;

    // Head-of-buffer beat selection: u/v count bytes, d/ss count 32-bit words.
    always_comb begin
        head_word  = buf_q[rptr_q];
        head_tag   = tag_q[rptr_q];
        head_valid = (cnt_q != 2'd0);
        beat_idx   = out_cnt_q[3:2];
        keep       = 4'hF;
        last_sec   = 1'b0;
        word_done  = 1'b1;
        step       = CNT_W'(1);
        unique case (head_tag)
            T_U:     sec_len = U_LEN;
            T_V:     sec_len = V_LEN;
            T_D:     sec_len = D_LEN;
            default: sec_len = SS_LEN;
        endcase
        remaining = sec_len - out_cnt_q;
        unique case (beat_idx)
            2'd0:    slice = head_word[RAMWIDTH-1  -: 32];
            2'd1:    slice = head_word[RAMWIDTH-33 -: 32];
            2'd2:    slice = head_word[RAMWIDTH-65 -: 32];
            default: slice = head_word[RAMWIDTH-97 -: 32];
        endcase
        if (head_tag[1]) begin
            step      = CNT_W'(4);
            last_sec  = (remaining <= CNT_W'(4));
            word_done = (beat_idx == 2'd3) || last_sec;
            if (remaining < CNT_W'(4)) begin
                unique case (remaining[1:0])
                    2'd1:    keep = 4'b1000;
                    2'd2:    keep = 4'b1100;
                    default: keep = 4'b1110;
                endcase
            end
        end else begin
            slice    = head_word[RAMWIDTH-1 -: 32];
            last_sec = (out_cnt_q == sec_len - CNT_W'(1));
        end
    end

    assign hs       = head_valid && dout_ready_i;
    assign pop      = hs && word_done;
    assign final_hs = hs && last_sec && (head_tag == T_SS);

    assign dout_valid_o    = head_valid;
    assign dout_keep_o     = head_valid ? keep : 4'b0000;
    assign dout_type_o     = head_valid ? head_tag : 2'd0;
    assign dout_last_sec_o = head_valid && last_sec;
    assign dout_last_o     = head_valid && last_sec && (head_tag == T_SS);
    assign dout_o          = head_valid ? (slice & {{8{keep[3]}}, {8{keep[2]}},
                                                    {8{keep[1]}}, {8{keep[0]}}}) : 32'd0;

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (hs) begin
            out_cnt_d = last_sec ? '0 : out_cnt_q + step;
        end
    end

    // Address and type only advance when the returning read lands, so they hold
    // for the whole time a read is in flight; reads are therefore never back-to-back.
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        rd_active = 1'b0;
        rd_type   = T_SS;
        rd_last   = '0;
        rd_next   = S_IDLE;
        unique case (state_q)
            S_U:     begin rd_active = 1'b1; rd_type = T_U;  rd_last = U_LAST;  rd_next = S_V;     end
            S_V:     begin rd_active = 1'b1; rd_type = T_V;  rd_last = V_LAST;  rd_next = S_D;     end
            S_D:     begin rd_active = 1'b1; rd_type = T_D;  rd_last = D_LAST;  rd_next = S_SS;    end
            S_SS:    begin rd_active = 1'b1; rd_type = T_SS; rd_last = SS_LAST; rd_next = S_FLUSH; end
            default: ;
        endcase
        issue = rd_active && !infl_q && ((cnt_q != 2'd2) || pop);
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_U;
                    rd_addr_d = '0;
                end
            end
            S_FLUSH: begin
                if (final_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                if (infl_q) begin
                    if (rd_addr_q == rd_last) begin
                        rd_addr_d = '0;
                        state_d   = rd_next;
                    end else begin
                        rd_addr_d = rd_addr_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign busy_o           = (state_q != S_IDLE);
    assign encap_out_en_o   = issue;
    assign encap_out_type_o = rd_type;
    assign encap_out_addr_o = rd_addr_q;

    assign cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            rd_addr_q <= '0;
            infl_q    <= 1'b0;
            cnt_q     <= 2'd0;
            wptr_q    <= 1'b0;
            rptr_q    <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_addr_q <= rd_addr_d;
            infl_q    <= issue;
            cnt_q     <= cnt_d;
            out_cnt_q <= out_cnt_d;
            if (infl_q) begin
                wptr_q <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    // The section tag is taken from the FSM while the read is still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            tag_q[0] <= 2'd0;
            tag_q[1] <= 2'd0;
        end else if (infl_q) begin
            buf_q[wptr_q] <= encap_out_i;
            tag_q[wptr_q] <= rd_type;
        end
    end

endmodule
